// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuild digit codes from a snooped 8-digit 7-segment scan
//
// Purpose: watches the multiplexed an/duan/duan1 drive of an 8-digit display,
// samples each position once its select has settled, assembles complete frames
// and publishes each new stable frame over a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   an[7:0]      digit select, active-high, bit i = position i (0 = rightmost)
//   duan[7:0]    segments for positions 0-3 (bit0..6 = a..g, bit7 = dp)
//   duan1[7:0]   segments for positions 4-7, same encoding
//   dig_code     published codes, position i in [4i+3:4i]
//   dig_dp       published decimal points, bit i = position i
//   frame_valid  published frame available
//   frame_ready  consumer accepts the frame
//   err_multi    1-cycle pulse: a bank had more than one select bit at a sample
//   err_overrun  sticky: pending frame was overwritten before being accepted
module seg_scan_decoder #(
  parameter int SETTLE     = 8,
  parameter int STABLE_FRM = 2,
  parameter int TIMEOUT    = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  duan,
  input  logic [7:0]  duan1,
  output logic [31:0] dig_code,
  output logic [7:0]  dig_dp,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        err_multi,
  output logic        err_overrun
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(STABLE_FRM + 1);

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   return 4'h0;
      7'h06:   return 4'h1;
      7'h5B:   return 4'h2;
      7'h4F:   return 4'h3;
      7'h66:   return 4'h4;
      7'h6D:   return 4'h5;
      7'h7D:   return 4'h6;
      7'h07:   return 4'h7;
      7'h7F:   return 4'h8;
      7'h6F:   return 4'h9;
      7'h40:   return 4'hA;  // minus sign
      7'h00:   return 4'hF;  // blank digit
      default: return 4'hE;
    endcase
  endfunction

  function automatic logic [1:0] bank_index(input logic [3:0] sel);
    case (sel)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic is_multi(input logic [3:0] sel);
    return (sel & (sel - 4'd1)) != 4'd0;
  endfunction

  function automatic logic is_one_hot(input logic [3:0] sel);
    return (sel != 4'd0) && !is_multi(sel);
  endfunction

  // Registered input copies; an_d is one cycle older to detect select changes.
  logic [7:0]    an_r, an_d, duan_r, duan1_r;
  logic [SW-1:0] settle;
  logic [7:0]    mask, mask_next;
  logic [31:0]   cap_code, prev_code, last_code, pend_code;
  logic [7:0]    cap_dp, prev_dp, last_dp, pend_dp;
  logic          prev_valid, last_valid, pend_full;
  logic [CW-1:0] stable, stable_next;
  logic [TW-1:0] tcnt;

  logic       an_chg, strobe, cap_lo, cap_hi, complete, match;
  logic       timeout_hit, publish_frame, accept;
  logic [1:0] lo_idx, hi_idx;

  assign an_chg = an_r != an_d;
  // Fires once per settled select: on the 7 -> 8 step of the saturating counter.
  assign strobe = !an_chg && (settle == SW'(SETTLE - 1));
  assign lo_idx = bank_index(an_r[3:0]);
  assign hi_idx = bank_index(an_r[7:4]);
  assign cap_lo = strobe && is_one_hot(an_r[3:0]);
  assign cap_hi = strobe && is_one_hot(an_r[7:4]);

  assign complete    = mask == 8'hFF;
  assign match       = prev_valid && ({cap_code, cap_dp} == {prev_code, prev_dp});
  assign timeout_hit = !complete && (mask != 8'h00) && (tcnt == TW'(TIMEOUT - 1));
  assign accept      = frame_valid && frame_ready;

  always_comb begin
    stable_next = CW'(1);
    if (match)
      stable_next = (stable == CW'(STABLE_FRM)) ? stable : stable + CW'(1);
  end

  assign publish_frame = complete && (stable_next >= CW'(STABLE_FRM)) &&
                         (!last_valid || ({cap_code, cap_dp} != {last_code, last_dp}));

  always_comb begin
    mask_next = mask;
    if (complete || timeout_hit) mask_next = 8'h00;
    if (cap_lo) mask_next[{1'b0, lo_idx}] = 1'b1;
    if (cap_hi) mask_next[{1'b1, hi_idx}] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r        <= '0;
      an_d        <= '0;
      duan_r      <= '0;
      duan1_r     <= '0;
      settle      <= '0;
      mask        <= '0;
      cap_code    <= '0;
      cap_dp      <= '0;
      prev_code   <= '0;
      prev_dp     <= '0;
      prev_valid  <= 1'b0;
      stable      <= '0;
      tcnt        <= '0;
      last_code   <= '0;
      last_dp     <= '0;
      last_valid  <= 1'b0;
      pend_code   <= '0;
      pend_dp     <= '0;
      pend_full   <= 1'b0;
      dig_code    <= 32'hFFFF_FFFF;
      dig_dp      <= '0;
      frame_valid <= 1'b0;
      err_multi   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      an_r    <= an;
      an_d    <= an_r;
      duan_r  <= duan;
      duan1_r <= duan1;

      if (an_chg)
        settle <= '0;
      else if (settle != SW'(SETTLE))
        settle <= settle + SW'(1);

      err_multi <= strobe && (is_multi(an_r[3:0]) || is_multi(an_r[7:4]));

      if (cap_lo) begin
        cap_code[{lo_idx, 2'b00} +: 4] <= seg_decode(duan_r[6:0]);
        cap_dp[{1'b0, lo_idx}]         <= duan_r[7];
      end
      if (cap_hi) begin
        cap_code[{1'b1, hi_idx, 2'b00} +: 4] <= seg_decode(duan1_r[6:0]);
        cap_dp[{1'b1, hi_idx}]               <= duan1_r[7];
      end
      mask <= mask_next;

      if (complete || timeout_hit || mask == 8'h00)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);

      if (complete) begin
        stable     <= stable_next;
        prev_code  <= cap_code;
        prev_dp    <= cap_dp;
        prev_valid <= 1'b1;
      end else if (timeout_hit) begin
        stable <= '0;
      end

      if (publish_frame) begin
        last_code  <= cap_code;
        last_dp    <= cap_dp;
        last_valid <= 1'b1;
        if (!frame_valid || (accept && !pend_full)) begin
          dig_code    <= cap_code;
          dig_dp      <= cap_dp;
          frame_valid <= 1'b1;
        end else if (accept) begin
          // Pending frame moves out, the new one takes its slot.
          dig_code  <= pend_code;
          dig_dp    <= pend_dp;
          pend_code <= cap_code;
          pend_dp   <= cap_dp;
        end else begin
          if (pend_full) err_overrun <= 1'b1;
          pend_code <= cap_code;
          pend_dp   <= cap_dp;
          pend_full <= 1'b1;
        end
      end else if (accept) begin
        if (pend_full) begin
          dig_code  <= pend_code;
          dig_dp    <= pend_dp;
          pend_full <= 1'b0;
        end else begin
          frame_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int TO = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an, duan, duan1;
  logic [31:0] dig_code;
  logic [7:0]  dig_dp;
  logic        frame_valid, err_multi, err_overrun;
  logic        frame_ready = 1'b0;
  logic        ready_set   = 1'b0;
  bit          rand_ready  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int fv_cycles    = 0;
  int multi_pulses = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(8), .STABLE_FRM(2), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .duan        (duan),
    .duan1       (duan1),
    .dig_code    (dig_code),
    .dig_dp      (dig_dp),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_multi   (err_multi),
    .err_overrun (err_overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] code, input logic dp);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h40;  4'hF: s = 7'h00;
      default: s = 7'h49;  // a+d+g: not a valid digit, decodes to E
    endcase
    return {dp, s};
  endfunction

  always @(posedge clk) begin
    #2;
    frame_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_set;
  end

  // Consumer side: every accepted frame must be the next expected one, and
  // outputs must hold while a frame waits for acceptance.
  logic [39:0] held_frame;
  bit          held_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (frame_valid) fv_cycles++;
      if (err_multi) multi_pulses++;
      if (frame_valid && held_v) check("hold_stable", {dig_code, dig_dp}, held_frame);
      if (frame_valid && frame_ready) begin
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("frame_data", {dig_code, dig_dp}, exp_q.pop_front());
      end
      held_frame = {dig_code, dig_dp};
      held_v     = frame_valid && !frame_ready;
    end
  end

  task automatic drive_an(input logic [7:0] a, input logic [31:0] code, input logic [7:0] dp,
                          input int hold);
    logic [7:0] lo, hi;
    lo = 8'($urandom);
    hi = 8'($urandom);
    for (int k = 0; k < 4; k++) if (a[k]) lo = seg_of(code[4*k +: 4], dp[k]);
    for (int k = 4; k < 8; k++) if (a[k]) hi = seg_of(code[4*k +: 4], dp[k]);
    @(posedge clk); #1;
    an = a; duan = lo; duan1 = hi;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic scan_frame(input logic [31:0] code, input logic [7:0] dp,
                            input int hmin, input int hmax);
    for (int i = 0; i < 8; i++) drive_an(8'(1 << i), code, dp, $urandom_range(hmin, hmax));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; an = 8'h00; duan = 8'h00; duan1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic settle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int fv0, mp0;
    logic [39:0] pool[3];
    logic [39:0] f, prev, last;
    bit have_prev, have_last;

    rst = 1'b1; an = 8'h00; duan = 8'h00; duan1 = 8'h00;
    settle_wait(3);
    check("rst_code", dig_code, 32'hFFFF_FFFF);
    check("rst_dp", dig_dp, 8'h00);
    check("rst_valid", frame_valid, 0);
    check("rst_multi", err_multi, 0);
    check("rst_overrun", err_overrun, 0);
    rst = 1'b0;
    settle_wait(20);
    check("idle_valid", frame_valid, 0);

    // Three identical frames publish exactly once.
    ready_set = 1'b1;
    fv0 = fv_cycles;
    exp_q.push_back({32'h1234_5678, 8'h00});
    repeat (3) scan_frame(32'h1234_5678, 8'h00, 16, 16);
    settle_wait(20);
    check("t1_fv_cycles", fv_cycles - fv0, 1);
    check("t1_queue", exp_q.size(), 0);
    check("t1_code", dig_code, 32'h1234_5678);

    // Alternating frames never become stable.
    do_reset();
    fv0 = fv_cycles;
    repeat (2) begin
      scan_frame(32'h0000_0001, 8'h00, 16, 16);
      scan_frame(32'h0000_0002, 8'h00, 16, 16);
    end
    settle_wait(20);
    check("t2_no_publish", fv_cycles - fv0, 0);

    // Both banks captured on one strobe, dp from the low bank.
    do_reset();
    exp_q.push_back({32'h9A57_0863, 8'h01});
    repeat (2) begin
      drive_an(8'h11, 32'h9A57_0863, 8'h01, 16);
      for (int i = 1; i < 8; i++)
        if (i != 4) drive_an(8'(1 << i), 32'h9A57_0863, 8'h01, 16);
    end
    settle_wait(20);
    check("t3_queue", exp_q.size(), 0);
    check("t3_dp0", dig_dp[0], 1);
    check("t3_code", dig_code, 32'h9A57_0863);

    // Two selects in a bank: one error pulse, nothing captured.
    do_reset();
    mp0 = multi_pulses;
    fv0 = fv_cycles;
    drive_an(8'h03, 32'h7654_3210, 8'h00, 16);
    check("t4_multi_once", multi_pulses - mp0, 1);
    for (int i = 2; i < 8; i++) drive_an(8'(1 << i), 32'h7654_3210, 8'h00, 16);
    drive_an(8'h03, 32'h7654_3210, 8'h00, 16);
    for (int i = 2; i < 8; i++) drive_an(8'(1 << i), 32'h7654_3210, 8'h00, 16);
    settle_wait(20);
    check("t4_multi_total", multi_pulses - mp0, 2);
    check("t4_no_publish", fv_cycles - fv0, 0);

    // Scan stalls past the timeout: partial frame discarded.
    do_reset();
    fv0 = fv_cycles;
    scan_frame(32'h3141_5926, 8'h00, 16, 16);
    for (int i = 0; i < 4; i++) drive_an(8'(1 << i), 32'h3141_5926, 8'h00, 16);
    drive_an(8'h10, 32'h3141_5926, 8'h00, TO + 100);
    for (int i = 5; i < 8; i++) drive_an(8'(1 << i), 32'h3141_5926, 8'h00, 16);
    scan_frame(32'h3141_5926, 8'h00, 16, 16);
    settle_wait(20);
    check("t5_no_publish", fv_cycles - fv0, 0);

    // Backpressure: second stable frame overwritten by the third.
    do_reset();
    ready_set = 1'b0;
    repeat (2) scan_frame(32'hA000_0001, 8'h00, 16, 16);
    repeat (2) scan_frame(32'hA000_0002, 8'h00, 16, 16);
    settle_wait(5);
    check("t6_no_overrun_yet", err_overrun, 0);
    repeat (2) scan_frame(32'hA000_0003, 8'h00, 16, 16);
    settle_wait(20);
    check("t6_code_held", dig_code, 32'hA000_0001);
    check("t6_valid", frame_valid, 1);
    check("t6_overrun", err_overrun, 1);
    exp_q.push_back({32'hA000_0001, 8'h00});
    exp_q.push_back({32'hA000_0003, 8'h00});
    ready_set = 1'b1;
    settle_wait(20);
    check("t6_queue", exp_q.size(), 0);
    check("t6_valid_drop", frame_valid, 0);
    check("t6_overrun_sticky", err_overrun, 1);

    // Asynchronous reset mid-scan with a pending frame and overrun set.
    do_reset();
    ready_set = 1'b0;
    repeat (2) scan_frame(32'h1111_1111, 8'h00, 16, 16);
    repeat (2) scan_frame(32'h2222_2222, 8'h00, 16, 16);
    repeat (2) scan_frame(32'h3333_3333, 8'h00, 16, 16);
    for (int i = 0; i < 4; i++) drive_an(8'(1 << i), 32'h4444_4444, 8'hFF, 16);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t7_rst_code", dig_code, 32'hFFFF_FFFF);
    check("t7_rst_dp", dig_dp, 8'h00);
    check("t7_rst_valid", frame_valid, 0);
    check("t7_rst_overrun", err_overrun, 0);
    settle_wait(2);
    rst = 1'b0; an = 8'h00;
    fv0 = fv_cycles;
    ready_set = 1'b1;
    settle_wait(60);
    check("t7_pending_dropped", fv_cycles - fv0, 0);

    // Random frames from a small pool; publish whenever a frame repeats its
    // predecessor and differs from what was last published.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 8; d++) begin
        int r;
        r = $urandom_range(0, 12);
        f[8 + 4*d +: 4] = (r < 10) ? 4'(r) : (r == 10) ? 4'hA : (r == 11) ? 4'hF : 4'hE;
      end
      f[39:36] = 4'(k);
      f[7:0]   = 8'($urandom);
      pool[k]  = f;
    end
    have_prev = 1'b0;
    have_last = 1'b0;
    prev = '0;
    last = '0;
    f = pool[0];
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if (n == 0 || $urandom_range(0, 1) == 0) f = pool[$urandom_range(0, 2)];
      if (have_prev && f == prev && (!have_last || f != last)) begin
        exp_q.push_back(f);
        last = f;
        have_last = 1'b1;
      end
      prev = f;
      have_prev = 1'b1;
      scan_frame(f[39:8], f[7:0], 12, 20);
    end
    rand_ready = 1'b0;
    ready_set  = 1'b1;
    settle_wait(60);
    check("rand_queue", exp_q.size(), 0);
    check("rand_overrun", err_overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
